ysyx_24110006_exu_seq: RTL and testbench

Multi-cycle instruction sequencer for the single-issue core. It drives the fetch, execute, memory and writeback phases around the combinational execute unit. It owns the PC, the instruction register, the writeback data register and the retired-instruction counter. It sits between the IFU/LSU handshake ports and the register file / CSR write ports.

---
 rtl/ysyx_24110006_exu_seq_if.sv | 44 ++++
 rtl/ysyx_24110006_exu_seq.sv | 122 ++++++++++++
 tb/tb_ysyx_24110006_exu_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110006_exu_seq_if.sv
// Handshake bundle between the multi-cycle sequencer and its IFU/EXU/LSU/RF/CSR neighbours.
// master is the sequencer side; slave is the surrounding core (or a testbench).
interface ysyx_24110006_exu_seq_if;
    logic [31:0] o_pc;
    logic        o_ifu_req;
    logic        i_ifu_valid;
    logic [31:0] i_ifu_inst;
    logic [31:0] o_inst;
    logic [31:0] i_exu_result;
    logic [31:0] i_exu_upc;
    logic        i_exu_jump;
    logic        i_exu_branch;
    logic        i_exu_trap;
    logic        i_exu_reg_wen;
    logic        i_exu_csr_wen;
    logic        i_exu_mem_ren;
    logic        i_exu_mem_wen;
    logic        i_ebreak;
    logic        o_lsu_req;
    logic        i_lsu_valid;
    logic [31:0] i_lsu_rdata;
    logic        o_rf_wen;
    logic [31:0] o_rf_wdata;
    logic        o_csr_wen;
    logic        o_retire;
    logic [31:0] o_instret;
    logic        o_halt;

    modport master (
        output o_pc, o_ifu_req, o_inst, o_lsu_req, o_rf_wen, o_rf_wdata,
               o_csr_wen, o_retire, o_instret, o_halt,
        input  i_ifu_valid, i_ifu_inst, i_exu_result, i_exu_upc, i_exu_jump,
               i_exu_branch, i_exu_trap, i_exu_reg_wen, i_exu_csr_wen,
               i_exu_mem_ren, i_exu_mem_wen, i_ebreak, i_lsu_valid, i_lsu_rdata
    );

    modport slave (
        input  o_pc, o_ifu_req, o_inst, o_lsu_req, o_rf_wen, o_rf_wdata,
               o_csr_wen, o_retire, o_instret, o_halt,
        output i_ifu_valid, i_ifu_inst, i_exu_result, i_exu_upc, i_exu_jump,
               i_exu_branch, i_exu_trap, i_exu_reg_wen, i_exu_csr_wen,
               i_exu_mem_ren, i_exu_mem_wen, i_ebreak, i_lsu_valid, i_lsu_rdata
    );
endinterface

// File: rtl/ysyx_24110006_exu_seq.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer around the combinational EXU.
// Owns PC, instruction register, writeback data and the retired-instruction counter; Moore outputs.
module ysyx_24110006_exu_seq #(
    parameter logic [31:0] RESET_PC      = 32'h8000_0000,
    parameter logic [31:0] RESET_INSTRET = 32'h0000_0000
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    ysyx_24110006_exu_seq_if.master        bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [2:0]  state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] inst_q,      inst_d;
    logic [31:0] wb_data_q,   wb_data_d;
    logic [31:0] tgt_q,       tgt_d;
    logic [31:0] instret_q,   instret_d;
    logic        rf_en_q,     rf_en_d;
    logic        csr_en_q,    csr_en_d;
    logic        redirect_q,  redirect_d;
    logic        halt_pend_q, halt_pend_d;
    logic        is_load_q,   is_load_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        wb_data_d   = wb_data_q;
        tgt_d       = tgt_q;
        instret_d   = instret_q;
        rf_en_d     = rf_en_q;
        csr_en_d    = csr_en_q;
        redirect_d  = redirect_q;
        halt_pend_d = halt_pend_q;
        is_load_d   = is_load_q;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.i_ifu_valid) begin
                    inst_d  = bus.i_ifu_inst;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Everything the later phases need is latched here so EXU inputs can move afterwards.
                wb_data_d   = bus.i_exu_result;
                rf_en_d     = bus.i_exu_reg_wen;
                csr_en_d    = bus.i_exu_csr_wen;
                redirect_d  = bus.i_exu_jump | bus.i_exu_branch | bus.i_exu_trap;
                tgt_d       = bus.i_exu_upc & ~32'h1;
                halt_pend_d = bus.i_ebreak;
                is_load_d   = bus.i_exu_mem_ren;
                state_d     = (bus.i_exu_mem_ren | bus.i_exu_mem_wen) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (bus.i_lsu_valid) begin
                    if (is_load_q) begin
                        wb_data_d = bus.i_lsu_rdata;
                    end
                    state_d = S_WB;
                end
            end
            S_WB: begin
                pc_d      = redirect_q ? tgt_q : pc_q + 32'd4;
                instret_d = instret_q + 32'd1;
                state_d   = halt_pend_q ? S_HALT : S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= NOP;
            wb_data_q   <= '0;
            tgt_q       <= '0;
            instret_q   <= RESET_INSTRET;
            rf_en_q     <= 1'b0;
            csr_en_q    <= 1'b0;
            redirect_q  <= 1'b0;
            halt_pend_q <= 1'b0;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            wb_data_q   <= wb_data_d;
            tgt_q       <= tgt_d;
            instret_q   <= instret_d;
            rf_en_q     <= rf_en_d;
            csr_en_q    <= csr_en_d;
            redirect_q  <= redirect_d;
            halt_pend_q <= halt_pend_d;
            is_load_q   <= is_load_d;
        end
    end

    assign bus.o_pc       = pc_q;
    assign bus.o_inst     = inst_q;
    assign bus.o_rf_wdata = wb_data_q;
    assign bus.o_instret  = instret_q;
    assign bus.o_ifu_req  = (state_q == S_FETCH);
    assign bus.o_lsu_req  = (state_q == S_MEM);
    assign bus.o_retire   = (state_q == S_WB);
    assign bus.o_rf_wen   = (state_q == S_WB) & rf_en_q;
    assign bus.o_csr_wen  = (state_q == S_WB) & csr_en_q;
    assign bus.o_halt     = (state_q == S_HALT);

endmodule

// File: tb/tb_ysyx_24110006_exu_seq.sv
// Cycle-by-cycle randomized bench for the sequencer against an instruction-level reference model.
// A second instance with a preloaded retire counter shares all inputs to observe counter wraparound.
module tb_ysyx_24110006_exu_seq;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_24110006_exu_seq_if bus ();
    ysyx_24110006_exu_seq_if bus2 ();

    ysyx_24110006_exu_seq #(.RESET_PC(RESET_PC)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus)
    );
    ysyx_24110006_exu_seq #(.RESET_PC(RESET_PC), .RESET_INSTRET(32'hFFFF_FFFF)) dut2 (
        .i_clock(clk), .i_reset_n(rst_n), .bus(bus2)
    );

    assign bus2.i_ifu_valid   = bus.i_ifu_valid;
    assign bus2.i_ifu_inst    = bus.i_ifu_inst;
    assign bus2.i_exu_result  = bus.i_exu_result;
    assign bus2.i_exu_upc     = bus.i_exu_upc;
    assign bus2.i_exu_jump    = bus.i_exu_jump;
    assign bus2.i_exu_branch  = bus.i_exu_branch;
    assign bus2.i_exu_trap    = bus.i_exu_trap;
    assign bus2.i_exu_reg_wen = bus.i_exu_reg_wen;
    assign bus2.i_exu_csr_wen = bus.i_exu_csr_wen;
    assign bus2.i_exu_mem_ren = bus.i_exu_mem_ren;
    assign bus2.i_exu_mem_wen = bus.i_exu_mem_wen;
    assign bus2.i_ebreak      = bus.i_ebreak;
    assign bus2.i_lsu_valid   = bus.i_lsu_valid;
    assign bus2.i_lsu_rdata   = bus.i_lsu_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    // Architectural model: where the PC should be and how many instructions have retired.
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_junk();
        bus.i_exu_result  = $urandom;
        bus.i_exu_upc     = $urandom;
        bus.i_exu_jump    = 1'($urandom_range(0, 1));
        bus.i_exu_branch  = 1'($urandom_range(0, 1));
        bus.i_exu_trap    = 1'($urandom_range(0, 1));
        bus.i_exu_reg_wen = 1'($urandom_range(0, 1));
        bus.i_exu_csr_wen = 1'($urandom_range(0, 1));
        bus.i_exu_mem_ren = 1'($urandom_range(0, 1));
        bus.i_exu_mem_wen = 1'($urandom_range(0, 1));
        bus.i_ebreak      = 1'($urandom_range(0, 1));
    endtask

    task automatic check_counters();
        check("instret", bus.o_instret, m_instret);
        check("instret_wrap", bus2.o_instret, m_instret + 32'hFFFF_FFFF);
    endtask

    task automatic check_reset_values();
        check("rst_pc", bus.o_pc, RESET_PC);
        check("rst_inst", bus.o_inst, 32'h0000_0013);
        check("rst_wdata", bus.o_rf_wdata, 32'h0);
        check("rst_instret", bus.o_instret, 32'h0);
        check("rst_instret2", bus2.o_instret, 32'hFFFF_FFFF);
        check("rst_strobes", {26'h0, bus.o_ifu_req, bus.o_lsu_req, bus.o_rf_wen,
                              bus.o_csr_wen, bus.o_retire, bus.o_halt}, 32'h0);
    endtask

    // Called with reset asserted; leaves the bench at the first FETCH-cycle negedge.
    task automatic reset_dut();
        m_pc = RESET_PC;
        m_instret = 32'h0;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        check("idle_ifu_req", 32'(bus.o_ifu_req), 32'h0);
        @(negedge clk);
    endtask

    task automatic do_instr(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] upc,
                            input logic [31:0] rdata, input logic jmp, input logic br, input logic trp,
                            input logic rwen, input logic cwen, input logic ren, input logic wen,
                            input logic ebrk, input int flat, input int mlat);
        logic [31:0] exp_wdata;
        for (int k = 0; k <= flat; k++) begin
            check("fetch_req", 32'(bus.o_ifu_req), 32'h1);
            check("fetch_pc", bus.o_pc, m_pc);
            check("fetch_noretire", {30'h0, bus.o_retire, bus.o_lsu_req}, 32'h0);
            bus.i_ifu_valid = (k == flat);
            bus.i_ifu_inst  = (k == flat) ? inst : $urandom;
            bus.i_lsu_valid = 1'($urandom_range(0, 1));
            bus.i_lsu_rdata = $urandom;
            drive_junk();
            @(negedge clk);
        end
        check("exec_inst", bus.o_inst, inst);
        check("exec_idle", {29'h0, bus.o_ifu_req, bus.o_lsu_req, bus.o_retire}, 32'h0);
        bus.i_ifu_valid   = 1'($urandom_range(0, 1));
        bus.i_ifu_inst    = $urandom;
        bus.i_lsu_valid   = 1'($urandom_range(0, 1));
        bus.i_exu_result  = res;
        bus.i_exu_upc     = upc;
        bus.i_exu_jump    = jmp;
        bus.i_exu_branch  = br;
        bus.i_exu_trap    = trp;
        bus.i_exu_reg_wen = rwen;
        bus.i_exu_csr_wen = cwen;
        bus.i_exu_mem_ren = ren;
        bus.i_exu_mem_wen = wen;
        bus.i_ebreak      = ebrk;
        @(negedge clk);
        if (ren | wen) begin
            for (int k = 0; k <= mlat; k++) begin
                check("mem_req", {30'h0, bus.o_lsu_req, bus.o_ifu_req}, 32'h2);
                check("mem_noretire", 32'(bus.o_retire), 32'h0);
                bus.i_lsu_valid = (k == mlat);
                bus.i_lsu_rdata = (k == mlat) ? rdata : $urandom;
                bus.i_ifu_valid = 1'($urandom_range(0, 1));
                drive_junk();
                @(negedge clk);
            end
        end
        exp_wdata = ren ? rdata : res;
        check("wb_retire", 32'(bus.o_retire), 32'h1);
        check("wb_rf_wen", 32'(bus.o_rf_wen), 32'(rwen));
        check("wb_csr_wen", 32'(bus.o_csr_wen), 32'(cwen));
        check("wb_wdata", bus.o_rf_wdata, exp_wdata);
        check("wb_reqs", {30'h0, bus.o_ifu_req, bus.o_lsu_req}, 32'h0);
        bus.i_ifu_valid = 1'($urandom_range(0, 1));
        bus.i_lsu_valid = 1'($urandom_range(0, 1));
        drive_junk();
        m_pc = (jmp | br | trp) ? (upc & ~32'h1) : m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
        @(negedge clk);
        check_counters();
        check("post_wb_pc", bus.o_pc, m_pc);
        check("post_wb_strobes", {29'h0, bus.o_rf_wen, bus.o_csr_wen, bus.o_retire}, 32'h0);
        if (ebrk) begin
            for (int k = 0; k < 5; k++) begin
                check("halt", 32'(bus.o_halt), 32'h1);
                check("halt_quiet", {28'h0, bus.o_ifu_req, bus.o_lsu_req, bus.o_retire, bus.o_rf_wen}, 32'h0);
                check("halt_pc", bus.o_pc, m_pc);
                bus.i_ifu_valid = 1'b1;
                bus.i_lsu_valid = 1'b1;
                drive_junk();
                @(negedge clk);
            end
        end else begin
            check("post_wb_halt", 32'(bus.o_halt), 32'h0);
        end
    endtask

    task automatic do_random();
        logic jmp, br, trp, rwen, cwen, ren, wen;
        {jmp, br, trp, rwen, cwen, ren, wen} = '0;
        case ($urandom_range(0, 6))
            0: rwen = 1'b1;
            1: br = 1'($urandom_range(0, 1));
            2: begin jmp = 1'b1; rwen = 1'b1; end
            3: begin ren = 1'b1; rwen = 1'b1; end
            4: wen = 1'b1;
            5: begin cwen = 1'b1; rwen = 1'b1; end
            default: trp = 1'b1;
        endcase
        do_instr($urandom, $urandom, $urandom, $urandom, jmp, br, trp, rwen, cwen, ren, wen, 1'b0,
                 $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    initial begin
        bus.i_ifu_valid = 1'b0;
        bus.i_ifu_inst  = '0;
        bus.i_lsu_valid = 1'b0;
        bus.i_lsu_rdata = '0;
        drive_junk();
        reset_dut();

        // addi, same-cycle fetch response
        do_instr(32'h0010_0093, 32'h1, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("addi_pc", bus.o_pc, 32'h8000_0004);
        // jal to odd target: bit 0 cleared
        do_instr(32'h0000_00EF, 32'h8000_0008, 32'h8000_0101, 32'h0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        check("jal_pc", bus.o_pc, 32'h8000_0100);
        // load, response on third MEM cycle
        do_instr(32'h0000_2083, 32'h1000_0000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2);
        // store
        do_instr(32'h0010_2023, 32'h1000_0004, 32'h0, 32'h5555_AAAA, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        // ecall to mtvec
        do_instr(32'h0000_0073, 32'h0, 32'h8000_0200, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("ecall_pc", bus.o_pc, 32'h8000_0200);
        // pc+4 wraparound from the top of the address space
        do_instr(32'h0000_0073, 32'h0, 32'hFFFF_FFFD, 32'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_instr(32'h0000_0013, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("pc_wrap", bus.o_pc, 32'h0);

        for (int n = 0; n < 150; n++) do_random();

        // reset asserted mid-MEM, with a stale LSU response held through reset and into FETCH
        check("abort_fetch_req", 32'(bus.o_ifu_req), 32'h1);
        bus.i_ifu_valid = 1'b1;
        bus.i_ifu_inst  = 32'h0000_2183;
        @(negedge clk);
        bus.i_ifu_valid   = 1'b0;
        bus.i_exu_mem_ren = 1'b1;
        bus.i_exu_mem_wen = 1'b0;
        bus.i_exu_reg_wen = 1'b1;
        bus.i_ebreak      = 1'b0;
        @(negedge clk);
        check("abort_in_mem", 32'(bus.o_lsu_req), 32'h1);
        bus.i_lsu_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        bus.i_lsu_valid = 1'b1;
        bus.i_lsu_rdata = 32'hBAD0_BAD0;
        reset_dut();
        bus.i_lsu_valid = 1'b1;
        check("abort_no_lsu_req", 32'(bus.o_lsu_req), 32'h0);
        check_counters();
        for (int n = 0; n < 20; n++) do_random();

        // ebreak: retires, then halts for good
        do_instr(32'h0010_0073, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
